// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect and decode handshake.
// Perf counter signals exist only when IF_PERF_CNT_EN is defined.
interface if_stage_fetch_if #(
    parameter int ADDR_W = 64
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [31:0]       imem_resp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_addr;
`ifdef IF_PERF_CNT_EN
    logic [63:0]       perf_fetch_cnt;
    logic [63:0]       perf_stall_cnt;
`endif

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, inst, inst_addr,
`ifdef IF_PERF_CNT_EN
        output perf_fetch_cnt, perf_stall_cnt,
`endif
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, inst, inst_addr,
`ifdef IF_PERF_CNT_EN
        input  perf_fetch_cnt, perf_stall_cnt,
`endif
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, one outstanding imem fetch, redirect with wrong-path drop.
// Optional IF_PERF_CNT_EN adds fetch/stall performance counters.
//
// state  | meaning
// S_IDLE | post-reset bubble, no request
// S_REQ  | request valid at pc, waiting for imem_req_ready
// S_WAIT | request accepted, waiting for imem_resp_valid
// S_HOLD | instruction presented to decode, waiting for if_ready
module if_stage_fetch #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter int          ADDR_W   = 64
) (
    input logic             clk,
    input logic             rst,
    if_stage_fetch_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              drop;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] inst_addr_q;
    logic [ADDR_W-1:0] redirect_tgt;

    assign redirect_tgt = bus.redirect_pc & ALIGN_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= PC_RESET[ADDR_W-1:0];
            drop        <= 1'b0;
            inst_q      <= 32'h0;
            inst_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.redirect_valid) begin
                        pc <= redirect_tgt;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.redirect_valid) begin
                        pc <= redirect_tgt;
                        // old address already handed to memory: its response must be dropped
                        if (bus.imem_req_ready) begin
                            state <= S_WAIT;
                            drop  <= 1'b1;
                        end
                    end else if (bus.imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_valid) begin
                        pc <= redirect_tgt;
                        if (bus.imem_resp_valid) begin
                            state <= S_REQ;
                            drop  <= 1'b0;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (bus.imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst_q      <= bus.imem_resp_data;
                            inst_addr_q <= pc;
                            pc          <= pc + ADDR_W'(4);
                            state       <= S_HOLD;
                        end
                    end
                end
                default: begin
                    if (bus.redirect_valid) begin
                        pc    <= redirect_tgt;
                        state <= S_REQ;
                    end else if (bus.if_ready) begin
                        state <= S_REQ;
                    end
                end
            endcase
        end
    end

    assign bus.imem_req_valid = (state == S_REQ);
    assign bus.imem_req_addr  = pc & ALIGN_MASK;
    assign bus.if_valid       = (state == S_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_addr      = inst_addr_q;

`ifdef IF_PERF_CNT_EN
    logic [63:0] perf_fetch_q;
    logic [63:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= 64'h0;
            perf_stall_q <= 64'h0;
        end else if (state == S_HOLD) begin
            if (bus.if_ready && !bus.redirect_valid) begin
                perf_fetch_q <= perf_fetch_q + 64'd1;
            end
            if (!bus.if_ready) begin
                perf_stall_q <= perf_stall_q + 64'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = perf_fetch_q;
    assign bus.perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch: a 1-cycle-response memory model plus manual response override.
module tb_if_stage_fetch;
    logic clk;
    logic rst;

    if_stage_fetch_if #(.ADDR_W(64)) bus ();

    if_stage_fetch #(
        .PC_RESET(64'h0000_0000_8000_0000),
        .ADDR_W  (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        mem_auto;
    logic        man_resp;
    logic [31:0] man_data;
    logic        pend;
    logic [63:0] pend_addr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0008) return 32'h0010_0093;
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_addr <= 64'h0;
        end else begin
            pend      <= bus.imem_req_valid && bus.imem_req_ready;
            pend_addr <= bus.imem_req_addr;
        end
    end

    assign bus.imem_resp_valid = mem_auto ? pend : man_resp;
    assign bus.imem_resp_data  = mem_auto ? mem_word(pend_addr) : man_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        mem_auto           = 1'b1;
        man_resp           = 1'b0;
        man_data           = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.if_ready       = 1'b1;
        tick();
        tick();
        chk("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        chk("rst_if_valid",  {63'h0, bus.if_valid}, 64'h0);
        chk("rst_inst",      {32'h0, bus.inst}, 64'h0);
        chk("rst_inst_addr", bus.inst_addr, 64'h0);
        chk("rst_req_addr",  bus.imem_req_addr, 64'h8000_0000);
        rst = 1'b0;

        // streaming, memory always ready, 1-cycle response
        tick();
        chk("s1_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("s1_req_addr",  bus.imem_req_addr, 64'h8000_0000);
        tick();
        chk("s1_wait_ifv",  {63'h0, bus.if_valid}, 64'h0);
        tick();
        chk("s1_ifv",       {63'h0, bus.if_valid}, 64'h1);
        chk("s1_inst_addr", bus.inst_addr, 64'h8000_0000);
        chk("s1_inst",      {32'h0, bus.inst}, 64'hDA5A_0000);
        tick();
        chk("s2_ifv_low",   {63'h0, bus.if_valid}, 64'h0);
        chk("s2_req_addr",  bus.imem_req_addr, 64'h8000_0004);
        tick();
        tick();
        chk("s2_ifv",       {63'h0, bus.if_valid}, 64'h1);
        chk("s2_inst_addr", bus.inst_addr, 64'h8000_0004);
        chk("s2_inst",      {32'h0, bus.inst}, 64'hDA5A_0004);
        tick();
        chk("s3_req_addr",  bus.imem_req_addr, 64'h8000_0008);
        tick();
        tick();
        chk("s3_inst",      {32'h0, bus.inst}, 64'h0010_0093);

        // decode stall for 5 cycles
        bus.if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ifv",       {63'h0, bus.if_valid}, 64'h1);
            chk("stall_inst",      {32'h0, bus.inst}, 64'h0010_0093);
            chk("stall_inst_addr", bus.inst_addr, 64'h8000_0008);
            chk("stall_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        end
        bus.if_ready = 1'b1;
        tick();
        chk("unstall_ifv",  {63'h0, bus.if_valid}, 64'h0);
        chk("unstall_addr", bus.imem_req_addr, 64'h8000_000C);

        // redirect while waiting, response arrives later
        mem_auto = 1'b0;
        man_resp = 1'b0;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0103;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rw_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        man_resp = 1'b1;
        man_data = 32'hDEAD_BEEF;
        tick();
        chk("rw_drop_ifv",  {63'h0, bus.if_valid}, 64'h0);
        chk("rw_req_valid2", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("rw_req_addr",  bus.imem_req_addr, 64'h8000_0100);
        man_resp = 1'b0;
        tick();
        man_resp = 1'b1;
        man_data = 32'h1234_5678;
        tick();
        chk("rw_ifv",       {63'h0, bus.if_valid}, 64'h1);
        chk("rw_inst_addr", bus.inst_addr, 64'h8000_0100);
        chk("rw_inst",      {32'h0, bus.inst}, 64'h1234_5678);
        man_resp = 1'b0;
        mem_auto = 1'b1;

        // redirect coinciding with the response
        tick();
        chk("rr_req_addr0", bus.imem_req_addr, 64'h8000_0104);
        tick();
        chk("rr_resp_now",  {63'h0, bus.imem_resp_valid}, 64'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2008;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rr_ifv",       {63'h0, bus.if_valid}, 64'h0);
        chk("rr_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("rr_req_addr",  bus.imem_req_addr, 64'h2008);
        tick();
        tick();
        chk("rr_ifv2",      {63'h0, bus.if_valid}, 64'h1);
        chk("rr_inst_addr", bus.inst_addr, 64'h2008);
        chk("rr_inst",      {32'h0, bus.inst}, 64'h5A5A_2008);

        // redirect in HOLD while decode is stalled
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h3000;
        tick();
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b1;
        chk("rh_ifv",       {63'h0, bus.if_valid}, 64'h0);
        chk("rh_req_addr",  bus.imem_req_addr, 64'h3000);
        tick();
        tick();
        chk("rh_inst_addr", bus.inst_addr, 64'h3000);

        // redirect in REQ while memory not ready: address moves
        bus.imem_req_ready = 1'b0;
        tick();
        chk("rq_req_addr0", bus.imem_req_addr, 64'h3004);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h4001;
        tick();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        chk("rq_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("rq_req_addr",  bus.imem_req_addr, 64'h4000);
        tick();
        tick();
        chk("rq_inst_addr", bus.inst_addr, 64'h4000);

        // redirect in REQ while memory accepts the old address
        tick();
        chk("ra_req_addr0", bus.imem_req_addr, 64'h4004);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h5002;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("ra_ifv",       {63'h0, bus.if_valid}, 64'h0);
        chk("ra_req_addr",  bus.imem_req_addr, 64'h5000);
        tick();
        tick();
        chk("ra_inst_addr", bus.inst_addr, 64'h5000);

        // PC wrap at top of address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wr_req_addr",  bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        tick();
        chk("wr_inst_addr", bus.inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_inst",      {32'h0, bus.inst}, 64'hA5A5_FFFC);
        tick();
        chk("wr_next_addr", bus.imem_req_addr, 64'h0);

        // reset mid-WAIT, late response after release
        mem_auto = 1'b0;
        man_resp = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mr_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        chk("mr_ifv",       {63'h0, bus.if_valid}, 64'h0);
        chk("mr_req_addr",  bus.imem_req_addr, 64'h8000_0000);
        tick();
        rst      = 1'b0;
        man_resp = 1'b1;
        man_data = 32'hCAFE_F00D;
        tick();
        chk("mr_late_ifv",  {63'h0, bus.if_valid}, 64'h0);
        chk("mr_req_valid2", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("mr_req_addr2", bus.imem_req_addr, 64'h8000_0000);
        man_resp = 1'b0;
        tick();
        man_resp = 1'b1;
        man_data = 32'h1111_1111;
        tick();
        man_resp = 1'b0;
        chk("mr_ifv2",      {63'h0, bus.if_valid}, 64'h1);
        chk("mr_inst",      {32'h0, bus.inst}, 64'h1111_1111);
        chk("mr_inst_addr", bus.inst_addr, 64'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
